// File: rtl/fetch_stage.sv
// fetch_stage: fetch unit that issues word-aligned imem requests and queues the
// in-order responses for decode, with redirect flush and access-fault halt.
//
// Ports
//   clk_i, rstn_i        clock, synchronous active-low reset
//   redirect_i/_pc_i     redirect request and target (low two bits ignored)
//   imem_req_*           request channel (valid/ready, word address)
//   imem_rsp_*           in-order response (valid, data, access fault)
//   dec_*                queue head to decode (valid/ready, pc, instr, fault)
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_instr_o,
  output logic            dec_fault_o
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW-1:0]   L_MAXO  = CW'(MAX_OUTST);
  localparam logic [CW:0]     L_DEPTH = (CW+1)'(FQ_DEPTH);
  localparam logic [XLEN-1:0] L_FOUR  = XLEN'(4);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [XLEN-1:0] r_q_pc    [FQ_DEPTH];
  logic [XLEN-1:0] r_q_instr [FQ_DEPTH];
  logic            r_q_err   [FQ_DEPTH];

  logic            w_req_valid;
  logic            w_acc;
  logic            w_deq;
  logic            w_enq;
  logic            w_rsp_drop;
  logic            w_dec_valid;
  logic            w_credit;
  logic [CW-1:0]   w_outst_nxt;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_unused_pc_lsb;

  assign w_redir_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  assign w_dec_valid = (r_cnt != '0);
  assign w_acc       = w_req_valid & imem_req_ready_i;
  assign w_deq       = w_dec_valid & dec_ready_i;
  assign w_rsp_drop  = imem_rsp_valid_i & (r_drop != '0);
  // A redirect flushes the queue, so a same-cycle response never lands.
  assign w_enq       = imem_rsp_valid_i & ~w_rsp_drop & ~redirect_i;
  assign w_outst_nxt = r_outst + CW'(w_acc) - CW'(imem_rsp_valid_i);
  // Queued plus in-flight never exceeds the depth, so no response can
  // arrive into a full queue.
  assign w_credit    = ({1'b0, r_cnt} + {1'b0, r_outst}) < L_DEPTH;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_i) begin
      w_state_nxt = S_RUN;
    end else if (w_enq && imem_rsp_err_i) begin
      w_state_nxt = S_HALT;
    end
  end

  always_comb begin
    w_req_valid = 1'b0;
    if (rstn_i && (r_state == S_RUN) && !redirect_i &&
        (r_outst < L_MAXO) && w_credit) begin
      w_req_valid = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= '0;
      r_drop   <= '0;
      r_cnt    <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
    end else if (redirect_i) begin
      r_pc     <= w_redir_pc;
      r_rsp_pc <= w_redir_pc;
      r_outst  <= w_outst_nxt;
      // Everything still in flight belongs to the old stream.
      r_drop   <= w_outst_nxt;
      r_cnt    <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      r_cnt   <= r_cnt + CW'(w_enq) - CW'(w_deq);
      if (w_acc) begin
        r_pc <= r_pc + L_FOUR;
      end
      if (w_rsp_drop) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_enq) begin
        r_wr     <= r_wr + AW'(1);
        r_rsp_pc <= r_rsp_pc + L_FOUR;
      end
      if (w_deq) begin
        r_rd <= r_rd + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_q_pc[r_wr]    <= r_rsp_pc;
      r_q_instr[r_wr] <= imem_rsp_err_i ? '0 : imem_rsp_data_i;
      r_q_err[r_wr]   <= imem_rsp_err_i;
    end
  end

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_pc;
  assign dec_valid_o      = w_dec_valid;
  // Head fields are masked while empty so stale entries never show.
  assign dec_pc_o         = w_dec_valid ? r_q_pc[r_rd]    : '0;
  assign dec_instr_o      = w_dec_valid ? r_q_instr[r_rd] : '0;
  assign dec_fault_o      = w_dec_valid & r_q_err[r_rd];

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table vectors plus hand sequences for fetch_stage,
// with an in-order latency-programmable imem model.
module tb_fetch_stage;

  logic        clk;
  logic        rstn, redirect, req_valid, req_ready;
  logic        rsp_valid, rsp_err, dec_valid, dec_ready, dec_fault;
  logic [31:0] redirect_pc, req_addr, rsp_data, dec_pc, dec_instr;

  logic        rstn6, redirect6, req_valid6, req_ready6;
  logic        rsp_valid6, rsp_err6, dec_valid6, dec_ready6, dec_fault6;
  logic [31:0] redirect_pc6, req_addr6, rsp_data6, dec_pc6, dec_instr6;

  fetch_stage #(
    .XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4), .MAX_OUTST(2)
  ) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
    .imem_req_addr_o(req_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .imem_rsp_err_i(rsp_err),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
    .dec_pc_o(dec_pc), .dec_instr_o(dec_instr), .dec_fault_o(dec_fault)
  );

  fetch_stage #(
    .XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(4), .MAX_OUTST(2)
  ) u_dut6 (
    .clk_i(clk), .rstn_i(rstn6),
    .redirect_i(redirect6), .redirect_pc_i(redirect_pc6),
    .imem_req_valid_o(req_valid6), .imem_req_ready_i(req_ready6),
    .imem_req_addr_o(req_addr6),
    .imem_rsp_valid_i(rsp_valid6), .imem_rsp_data_i(rsp_data6),
    .imem_rsp_err_i(rsp_err6),
    .dec_valid_o(dec_valid6), .dec_ready_i(dec_ready6),
    .dec_pc_o(dec_pc6), .dec_instr_o(dec_instr6), .dec_fault_o(dec_fault6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } del_t;

  typedef struct {
    logic        rdy;
    logic        dr;
    logic        ev;
    logic [31:0] ea;
    logic        dv;
    logic [31:0] dp;
  } vec_t;

  mreq_t       mq[$];
  del_t        dlog[$];
  del_t        dlog6[$];
  vec_t        tv[21];
  int          cyc, lat, nacc;
  int          nchk, nerr;
  logic        err_en;
  logic [31:0] err_addr;

  function automatic logic [31:0] f_instr(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic        a0, d0, r0, a1, d1;
    logic [31:0] ad0, ad1;
    #1;
    a0  = req_valid & req_ready;
    ad0 = req_addr;
    d0  = dec_valid & dec_ready;
    r0  = rsp_valid;
    a1  = req_valid6 & req_ready6;
    ad1 = req_addr6;
    d1  = dec_valid6 & dec_ready6;
    if (d0) dlog.push_back('{dec_pc, dec_instr, dec_fault});
    if (d1) dlog6.push_back('{dec_pc6, dec_instr6, dec_fault6});
    @(posedge clk);
    #1;
    cyc++;
    if (!rstn) begin
      mq.delete();
    end else begin
      if (r0 && mq.size() > 0) void'(mq.pop_front());
      if (a0) begin
        mq.push_back('{ad0, cyc + lat - 1});
        nacc++;
      end
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = f_instr(mq[0].addr);
      rsp_err   = err_en && (mq[0].addr == err_addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
      rsp_err   = 1'b0;
    end
    rsp_valid6 = a1 & rstn6;
    rsp_data6  = f_instr(ad1);
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    redirect  = 1'b0;
    req_ready = 1'b1;
    dec_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    nacc = 0;
    dlog.delete();
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req_ready = tv[i].rdy;
      dec_ready = tv[i].dr;
      #1;
      chk($sformatf("row%0d_req_valid", i), 32'(req_valid), 32'(tv[i].ev));
      chk($sformatf("row%0d_req_addr", i), req_addr, tv[i].ea);
      chk($sformatf("row%0d_dec_valid", i), 32'(dec_valid), 32'(tv[i].dv));
      chk($sformatf("row%0d_dec_pc", i), dec_pc, tv[i].dp);
      chk($sformatf("row%0d_dec_instr", i), dec_instr,
          tv[i].dv ? f_instr(tv[i].dp) : 32'h0);
      tick();
    end
  endtask

  task automatic wait_deliver(input string nm, input logic [31:0] epc);
    int n;
    n = 0;
    while (dlog.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_seen"}, 32'(dlog.size() != 0), 32'd1);
    if (dlog.size() != 0) begin
      chk({nm, "_pc"}, dlog[0].pc, epc);
      chk({nm, "_instr"}, dlog[0].instr, f_instr(epc));
      chk({nm, "_fault"}, 32'(dlog[0].fault), 32'd0);
    end
  endtask

  initial begin
    nchk = 0; nerr = 0; cyc = 0; nacc = 0; lat = 1;
    err_en = 1'b0; err_addr = 32'h8;
    rstn = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    req_ready = 1'b1; dec_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;
    rstn6 = 1'b0; redirect6 = 1'b0; redirect_pc6 = 32'h0;
    req_ready6 = 1'b1; dec_ready6 = 1'b1;
    rsp_valid6 = 1'b0; rsp_data6 = 32'h0; rsp_err6 = 1'b0;

    tv[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    for (int i = 10; i <= 15; i++)
      tv[i] = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tv[16] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    tv[17] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    tv[18] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
    tv[19] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
    tv[20] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    tick();
    tick();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_dec_fault", 32'(dec_fault), 32'd0);
    chk("rst6_req_addr", req_addr6, 32'hFFFF_FFF8);
    chk("rst6_dec_valid", 32'(dec_valid6), 32'd0);

    // T1: 1-cycle memory, decode always ready
    rstn = 1'b1;
    nacc = 0;
    dlog.delete();
    run_rows(0, 5);

    // T2: decode stalled, queue fills by credit, then drains in order
    do_reset();
    run_rows(6, 15);
    chk("t2_req_count", 32'(nacc), 32'd4);
    run_rows(16, 20);
    chk("t2_dlog_size", 32'(dlog.size() >= 4), 32'd1);
    if (dlog.size() >= 4) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("t2_deliver%0d", k), dlog[k].pc, 32'(4 * k));
    end

    // T3: two requests in flight at latency 3, redirect drops both
    lat = 3;
    do_reset();
    tick();
    tick();
    #1;
    chk("t3_outst_cap", 32'(req_valid), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    #1;
    chk("t3_q_empty", 32'(dec_valid), 32'd0);
    chk("t3_no_req", 32'(req_valid), 32'd0);
    chk("t3_none_before", 32'(dlog.size()), 32'd0);
    wait_deliver("t3_first", 32'h100);

    // T4: access fault at PC 8 halts fetch until redirect
    lat = 1;
    err_en = 1'b1;
    do_reset();
    repeat (10) tick();
    #1;
    chk("t4_dlog_size", 32'(dlog.size()), 32'd4);
    if (dlog.size() >= 4) begin
      chk("t4_fault_pc", dlog[2].pc, 32'h8);
      chk("t4_fault_flag", 32'(dlog[2].fault), 32'd1);
      chk("t4_fault_instr", dlog[2].instr, 32'h0);
      chk("t4_drain_pc", dlog[3].pc, 32'hC);
      chk("t4_drain_fault", 32'(dlog[3].fault), 32'd0);
    end
    chk("t4_halt_req", 32'(req_valid), 32'd0);
    chk("t4_req_count", 32'(nacc), 32'd4);
    err_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("t4_redir_noreq", 32'(req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_resume_valid", 32'(req_valid), 32'd1);
    chk("t4_resume_addr", req_addr, 32'h40);
    dlog.delete();
    wait_deliver("t4_resume", 32'h40);

    // T5: unaligned target, redirect coincident with response and dequeue
    do_reset();
    repeat (3) tick();
    #1;
    chk("t5_pre_valid", 32'(dec_valid), 32'd1);
    chk("t5_pre_pc", dec_pc, 32'h4);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    #1;
    chk("t5_delivered", 32'(dlog.size()), 32'd2);
    chk("t5_q_empty", 32'(dec_valid), 32'd0);
    chk("t5_req_valid", 32'(req_valid), 32'd1);
    chk("t5_req_addr", req_addr, 32'h200);
    dlog.delete();
    wait_deliver("t5_first", 32'h200);
    tick();
    chk("t5_second_seen", 32'(dlog.size() >= 2), 32'd1);
    if (dlog.size() >= 2) chk("t5_second_pc", dlog[1].pc, 32'h204);

    // T5b: back-to-back redirects while stale responses are in flight
    lat = 3;
    do_reset();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h500;
    tick();
    redirect = 1'b0;
    #1;
    chk("t5b_req_valid", 32'(req_valid), 32'd1);
    chk("t5b_req_addr", req_addr, 32'h500);
    dlog.delete();
    wait_deliver("t5b_first", 32'h500);

    // T6: PC wrap from RESET_PC near the top of the address space
    dlog6.delete();
    rstn6 = 1'b1;
    repeat (8) tick();
    chk("t6_dlog_size", 32'(dlog6.size() >= 3), 32'd1);
    if (dlog6.size() >= 3) begin
      chk("t6_pc0", dlog6[0].pc, 32'hFFFF_FFF8);
      chk("t6_pc1", dlog6[1].pc, 32'hFFFF_FFFC);
      chk("t6_pc2", dlog6[2].pc, 32'h0000_0000);
      chk("t6_instr2", dlog6[2].instr, f_instr(32'h0));
    end

    // Reset in the middle of a running burst
    lat = 1;
    repeat (10) tick();
    #1;
    chk("mid_burst_active", 32'(dec_valid), 32'd1);
    rstn = 1'b0;
    tick();
    #1;
    chk("mid_req_valid", 32'(req_valid), 32'd0);
    chk("mid_req_addr", req_addr, 32'h0);
    chk("mid_dec_valid", 32'(dec_valid), 32'd0);
    chk("mid_dec_pc", dec_pc, 32'h0);
    chk("mid_dec_instr", dec_instr, 32'h0);
    chk("mid_dec_fault", 32'(dec_fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
